// File: rtl/sequenciador_ula_pkg.sv
// Shared types and widths for the ALU operation sequencer.
package sequenciador_ula_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    StIdle      = 3'd0,
    StOpWait    = 3'd1,
    StBWait     = 3'd2,
    StExecReady = 3'd3,
    StExec      = 3'd4,
    StShow      = 3'd5
  } state_t;

endpackage

// File: rtl/sequenciador_ula_if.sv
// Button levels in, register strobes and status out.
interface sequenciador_ula_if;
  import sequenciador_ula_pkg::*;

  logic               entrada_numero;
  logic               entrada_operacao;
  logic               executar;
  logic               load_a;
  logic               a_from_result;
  logic               load_op;
  logic               load_b;
  logic               start_exec;
  logic               load_result;
  logic               pronto;
  logic               erro;
  logic [STATE_W-1:0] estado;

  // Button side: drives levels, observes strobes.
  modport master (
    output entrada_numero, entrada_operacao, executar,
    input  load_a, a_from_result, load_op, load_b, start_exec, load_result, pronto, erro,
           estado
  );

  // Sequencer side.
  modport slave (
    input  entrada_numero, entrada_operacao, executar,
    output load_a, a_from_result, load_op, load_b, start_exec, load_result, pronto, erro,
           estado
  );
endinterface

// File: rtl/detector_borda.sv
// Button conditioner: 2-FF synchronizer, optional debounce, rising-edge detect.
// Debounce is built when SEQ_DEBOUNCE_EN is defined.
module detector_borda #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic nivel,
  output logic evento
);

  logic sync1_q, sync2_q;
  logic aceito, aceito_prev_q;

  // Two-stage synchronizer for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= nivel;
      sync2_q <= sync1_q;
    end
  end

`ifdef SEQ_DEBOUNCE_EN
  logic       aceito_q;
  logic [7:0] db_cnt_q;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aceito_q <= 1'b0;
      db_cnt_q <= 8'd0;
    end else if (sync2_q != aceito_q) begin
      if (db_cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        aceito_q <= sync2_q;
        db_cnt_q <= 8'd0;
      end else begin
        db_cnt_q <= db_cnt_q + 8'd1;
      end
    end else begin
      db_cnt_q <= 8'd0;
    end
  end

  assign aceito = aceito_q;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign aceito = sync2_q;
`endif

  // Previous accepted level, for the rising-edge event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) aceito_prev_q <= 1'b0;
    else     aceito_prev_q <= aceito;
  end

  assign evento = aceito & ~aceito_prev_q;

endmodule

// File: rtl/sequenciador_ula.sv
// ALU operation sequencer: button events -> one-cycle register strobes in the
// order A, op, B, execute, result. Optional SEQ_DEBOUNCE_EN adds input debounce.
module sequenciador_ula
  import sequenciador_ula_pkg::*;
#(
  parameter int unsigned EXEC_LATENCY    = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  sequenciador_ula_if.slave bus
);

  logic ev_num, ev_op, ev_exe;

  detector_borda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_det_num (
    .clk(clk), .rst(rst), .nivel(bus.entrada_numero), .evento(ev_num)
  );
  detector_borda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_det_op (
    .clk(clk), .rst(rst), .nivel(bus.entrada_operacao), .evento(ev_op)
  );
  detector_borda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_det_exe (
    .clk(clk), .rst(rst), .nivel(bus.executar), .evento(ev_exe)
  );

  logic [1:0] n_ev;
  logic       multi, single;
  assign n_ev   = 2'(ev_num) + 2'(ev_op) + 2'(ev_exe);
  assign multi  = (n_ev > 2'd1);
  assign single = (n_ev == 2'd1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic load_a_q, a_from_result_q, load_op_q, load_b_q, start_exec_q, load_result_q;
  logic pronto_q, erro_q;

  // Sequencer FSM with latency counter and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      load_a_q        <= 1'b0;
      a_from_result_q <= 1'b0;
      load_op_q       <= 1'b0;
      load_b_q        <= 1'b0;
      start_exec_q    <= 1'b0;
      load_result_q   <= 1'b0;
      pronto_q        <= 1'b0;
      erro_q          <= 1'b0;
    end else begin
      load_a_q        <= 1'b0;
      a_from_result_q <= 1'b0;
      load_op_q       <= 1'b0;
      load_b_q        <= 1'b0;
      start_exec_q    <= 1'b0;
      load_result_q   <= 1'b0;
      pronto_q        <= 1'b0;
      if (multi) erro_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (single) begin
            if (ev_num) begin
              load_a_q <= 1'b1;
              erro_q   <= 1'b0;
              state_q  <= StOpWait;
            end else erro_q <= 1'b1;
          end
        end
        StOpWait: begin
          if (single) begin
            if (ev_op) begin
              load_op_q <= 1'b1;
              erro_q    <= 1'b0;
              state_q   <= StBWait;
            end else erro_q <= 1'b1;
          end
        end
        StBWait: begin
          if (single) begin
            if (ev_num) begin
              load_b_q <= 1'b1;
              erro_q   <= 1'b0;
              state_q  <= StExecReady;
            end else erro_q <= 1'b1;
          end
        end
        StExecReady: begin
          if (single) begin
            if (ev_num) begin
              load_b_q <= 1'b1;
              erro_q   <= 1'b0;
            end else if (ev_exe) begin
              start_exec_q <= 1'b1;
              erro_q       <= 1'b0;
              cnt_q        <= CNT_W'(EXEC_LATENCY);
              state_q      <= StExec;
            end else erro_q <= 1'b1;
          end
        end
        StExec: begin
          // Presses are illegal here, but the latency count runs regardless.
          if (single) erro_q <= 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            load_result_q <= 1'b1;
            state_q       <= StShow;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StShow: begin
          pronto_q <= 1'b1;
          if (single) begin
            if (ev_num) begin
              load_a_q <= 1'b1;
              erro_q   <= 1'b0;
              pronto_q <= 1'b0;
              state_q  <= StOpWait;
            end else if (ev_op) begin
              load_a_q        <= 1'b1;
              a_from_result_q <= 1'b1;
              load_op_q       <= 1'b1;
              erro_q          <= 1'b0;
              pronto_q        <= 1'b0;
              state_q         <= StBWait;
            end else erro_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          erro_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.load_a        = load_a_q;
  assign bus.a_from_result = a_from_result_q;
  assign bus.load_op       = load_op_q;
  assign bus.load_b        = load_b_q;
  assign bus.start_exec    = start_exec_q;
  assign bus.load_result   = load_result_q;
  assign bus.pronto        = pronto_q;
  assign bus.erro          = erro_q;
  assign bus.estado        = state_q;

endmodule

// File: doc/sequenciador_ula.md
# sequenciador_ula

Operation sequencer for the ALU front end. Converts the three user push-button levels (number entry, operation entry, execute) into one-cycle register-load and execute strobes in the fixed order operand A → operation → operand B → execute → result. Sits between the raw button inputs and the operand, opcode and result registers. Replaces per-input gated clocks with clock enables in the single `clk` domain.

## Interface
Parameters:
- `EXEC_LATENCY`, 2: cycles from `start_exec` to `load_result`; legal range 1–15.
- `DEBOUNCE_CYCLES`, 4: stable samples required per press; used only with the debounce feature; legal range 2–255.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `entrada_numero`  in  1  number button level, asynchronous.
- `entrada_operacao`  in  1  operation button level, asynchronous.
- `executar`  in  1  execute button level, asynchronous.
- `load_a`  out  1  one-cycle enable for operand A register.
- `a_from_result`  out  1  operand-A mux select; valid only while `load_a`=1; 1 = load from result register.
- `load_op`  out  1  one-cycle enable for opcode register.
- `load_b`  out  1  one-cycle enable for operand B register.
- `start_exec`  out  1  one-cycle ALU start strobe.
- `load_result`  out  1  one-cycle enable for result register.
- `pronto`  out  1  high while a valid result is held.
- `erro`  out  1  sticky out-of-order-press flag.
- `estado`  out  3  current state code.

## Operation
- Each button passes through a 2-FF synchronizer and a rising-edge detector, producing a one-cycle press event. Holding a button produces exactly one event.
- States and codes:
  - IDLE (0): numero → `load_a`, next OP_WAIT.
  - OP_WAIT (1): operacao → `load_op`, next B_WAIT.
  - B_WAIT (2): numero → `load_b`, next EXEC_READY.
  - EXEC_READY (3): numero → `load_b` again and remain (overwrite B); executar → `start_exec`, next EXEC.
  - EXEC (4): counter loads `EXEC_LATENCY` and decrements each cycle. At expiry, pulse `load_result` and move to SHOW.
  - SHOW (5): numero → `load_a` with `a_from_result`=0, next OP_WAIT (new calculation). operacao → `load_a` with `a_from_result`=1 and `load_op` in the same cycle, next B_WAIT (chaining).
- Any press not listed for the current state sets `erro`; state and strobes are unchanged. This includes any press during EXEC.
- Two or more press events in the same cycle: no strobe and no transition, `erro` set.
- `erro` clears on the next legal press, in the same cycle as that press's strobe.
- Codes 6–7 are unreachable. If entered, the next state is IDLE with `erro` set.

## Timing
- All outputs are registered. Every strobe is exactly one cycle wide.
- Reset value of every output is 0; `estado`=0 (IDLE).
- Press latency, debounce disabled: a strobe is high in the cycle following the 3rd rising edge counted from the first edge that samples the button high.
- `load_result` is high exactly `EXEC_LATENCY` cycles after the `start_exec` cycle.
- `pronto` rises the cycle after `load_result`. It falls in the cycle of the strobe that leaves SHOW.
- Reset mid-operation: the FSM, counter and synchronizers are cleared immediately. A button still held at reset release produces one press event.

## Configuration
- `SEQ_DEBOUNCE_EN` defined: a synchronized level must be stable for `DEBOUNCE_CYCLES` consecutive samples before it is accepted. The edge detector acts on the accepted level. Press latency increases by `DEBOUNCE_CYCLES`. Glitches shorter than that produce no event.
- `SEQ_DEBOUNCE_EN` undefined: synchronizer plus edge detect only. `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `sequenciador_ula_pkg`:
  - state code constants (IDLE … SHOW);
  - state width 3;
  - counter width 4.
- Sub-module `detector_borda`: synchronizer, optional debounce and edge detect. Instantiated three times, once per button.
- The FSM, latency counter and output registers live in the top module.

## Test plan
- Full sequence, `EXEC_LATENCY`=2: press numero, operacao, numero, executar. Expect `load_a`, `load_op`, `load_b`, `start_exec` one cycle each, then `load_result` 2 cycles after `start_exec`, `pronto`=1 and `estado`=5.
- Chaining from SHOW: press operacao. Expect `load_a`=1, `a_from_result`=1 and `load_op`=1 in the same cycle; `estado`=2.
- Out of order: executar in IDLE → `erro`=1, `estado`=0, no strobes. A following numero → `load_a`=1, `erro`=0.
- Simultaneous: numero and operacao rise on the same edge in OP_WAIT → `erro`=1, no strobe, `estado`=1.
- Reset asserted during EXEC → all outputs 0 immediately; after release, `estado`=0 and no `load_result` appears.
- With `SEQ_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4: a 3-cycle glitch on numero → no strobe; a 10-cycle press → exactly one `load_a`, 4 cycles later than without debounce.
